// File: rtl/lfsr_run_stats_pkg.sv
// Shared types, default sizes and helpers for the LFSR run-length statistics block.
package lfsr_stats_pkg;

  localparam int unsigned LRS_NUM_BINS = 24;
  localparam int unsigned LRS_CNT_W    = 22;
  localparam int unsigned LRS_RUN_W    = 6;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  // Increment that holds at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_v) ? value : value + 32'd1;
  endfunction

  // Runs at or beyond num_bins all collapse into the last bin.
  function automatic int unsigned bin_index(input int unsigned run_len, input int unsigned num_bins);
    return (run_len >= num_bins) ? num_bins - 1 : run_len - 1;
  endfunction

endpackage

// File: rtl/lfsr_run_stats_if.sv
// Stimulus/readout bundle between the LFSR side and the run statistics block.
interface lfsr_run_stats_if
  import lfsr_stats_pkg::*;
#(
  parameter int unsigned NUM_BINS = LRS_NUM_BINS,
  parameter int unsigned CNT_W    = LRS_CNT_W,
  parameter int unsigned RUN_W    = LRS_RUN_W
);
  localparam int unsigned BIN_IDX_W = $clog2(NUM_BINS);

  logic                 val;
  logic                 loop;
  logic                 rearm;
  logic                 rd_pol;
  logic [BIN_IDX_W-1:0] rd_bin;
  logic [CNT_W-1:0]     rd_data;
  logic [CNT_W-1:0]     total_runs;
  logic [RUN_W-1:0]     longest_run;
  logic                 busy;
  logic                 done;

  modport master (
    output val, loop, rearm, rd_pol, rd_bin,
    input  rd_data, total_runs, longest_run, busy, done
  );

  modport slave (
    input  val, loop, rearm, rd_pol, rd_bin,
    output rd_data, total_runs, longest_run, busy, done
  );

endinterface

// File: rtl/lfsr_run_stats_run_bin_store.sv
// Two polarities x NUM_BINS saturating run counters with clear and registered read.
module run_bin_store
  import lfsr_stats_pkg::*;
#(
  parameter int unsigned NB = LRS_NUM_BINS,
  parameter int unsigned CW = LRS_CNT_W,
  parameter int unsigned IW = $clog2(NB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic          i_inc_pol,
  input  logic [IW-1:0] i_inc_idx,
  input  logic          i_rd_pol,
  input  logic [IW-1:0] i_rd_bin,
  output logic [CW-1:0] o_rd_data
);

  logic [CW-1:0] r_bins [2][NB];
  logic [CW-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      for (int p = 0; p < 2; p++) begin
        for (int b = 0; b < int'(NB); b++) begin
          r_bins[p][b] <= '0;
        end
      end
    end else if (i_inc) begin
      r_bins[i_inc_pol][i_inc_idx] <= CW'(sat_inc(32'(r_bins[i_inc_pol][i_inc_idx]), CW));
    end
  end

  // Indices past the last bin read as zero rather than aliasing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (32'(i_rd_bin) < NB) begin
      r_rd_data <= r_bins[i_rd_pol][i_rd_bin];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lfsr_run_stats.sv
// Run-length histogram of the LFSR bit stream over one period, frozen until rearmed.
module lfsr_run_stats
  import lfsr_stats_pkg::*;
#(
  parameter int unsigned NUM_BINS = LRS_NUM_BINS,
  parameter int unsigned CNT_W    = LRS_CNT_W,
  parameter int unsigned RUN_W    = LRS_RUN_W
) (
  input logic             clk,
  input logic             reset,
  lfsr_run_stats_if.slave bus
);

  localparam int unsigned BIN_IDX_W = $clog2(NUM_BINS);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_prev_bit;
  logic [RUN_W-1:0]     r_run_len;
  logic [CNT_W-1:0]     r_total_runs;
  logic [RUN_W-1:0]     r_longest_run;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_close;
  logic                 w_start;
  logic                 w_extend;
  logic                 w_clr;
  logic [BIN_IDX_W-1:0] w_bin_idx;
  logic [CNT_W-1:0]     w_rd_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A loop in ACTIVE closes the open run and drops that cycle's bit.
  always_comb begin
    w_state_nxt = r_state;
    w_close     = 1'b0;
    w_start     = 1'b0;
    w_extend    = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.loop) begin
          w_state_nxt = ACTIVE;
          w_start     = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.loop) begin
          w_close     = 1'b1;
          w_state_nxt = DONE;
        end else if (bus.val != r_prev_bit) begin
          w_close = 1'b1;
          w_start = 1'b1;
        end else begin
          w_extend = 1'b1;
        end
      end
      DONE: begin
        if (bus.rearm) begin
          w_clr       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_bin_idx = BIN_IDX_W'(bin_index(32'(r_run_len), NUM_BINS));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_bit    <= 1'b0;
      r_run_len     <= '0;
      r_total_runs  <= '0;
      r_longest_run <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ACTIVE);
      r_done <= (w_state_nxt == DONE);
      if (w_clr) begin
        r_prev_bit    <= 1'b0;
        r_run_len     <= '0;
        r_total_runs  <= '0;
        r_longest_run <= '0;
      end
      if (w_close) begin
        r_total_runs <= CNT_W'(sat_inc(32'(r_total_runs), CNT_W));
        if (r_run_len > r_longest_run) begin
          r_longest_run <= r_run_len;
        end
      end
      if (w_start) begin
        r_prev_bit <= bus.val;
        r_run_len  <= RUN_W'(1);
      end else if (w_extend) begin
        r_run_len <= RUN_W'(sat_inc(32'(r_run_len), RUN_W));
      end
    end
  end

  run_bin_store #(
    .NB (NUM_BINS),
    .CW (CNT_W),
    .IW (BIN_IDX_W)
  ) u_bins (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_inc     (w_close),
    .i_inc_pol (r_prev_bit),
    .i_inc_idx (w_bin_idx),
    .i_rd_pol  (bus.rd_pol),
    .i_rd_bin  (bus.rd_bin),
    .o_rd_data (w_rd_data)
  );

  assign bus.rd_data     = w_rd_data;
  assign bus.total_runs  = r_total_runs;
  assign bus.longest_run = r_longest_run;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_lfsr_run_stats.sv
// Directed bench for lfsr_run_stats: hand-computed run histograms, rearm, reset and read-port edges.
module tb_lfsr_run_stats;
  import lfsr_stats_pkg::*;

  localparam int unsigned NB = LRS_NUM_BINS;
  localparam int unsigned CW = LRS_CNT_W;
  localparam int unsigned RW = LRS_RUN_W;
  localparam int unsigned IW = $clog2(NB);

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   exp_bins [2][NB];

  lfsr_run_stats_if #(.NUM_BINS(NB), .CNT_W(CW), .RUN_W(RW)) bus ();

  lfsr_run_stats #(.NUM_BINS(NB), .CNT_W(CW), .RUN_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic l);
    bus.val  = v;
    bus.loop = l;
    step();
    bus.loop = 1'b0;
  endtask

  task automatic read_bin(input logic pol, input int bin, input int expv, input string tag);
    bus.rd_pol = pol;
    bus.rd_bin = IW'(bin);
    step();
    chk(tag, 32'(bus.rd_data), 32'(expv));
  endtask

  task automatic clear_exp();
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < int'(NB); b++) exp_bins[p][b] = 0;
    end
  endtask

  task automatic check_all_bins(input string tag);
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < int'(NB); b++) begin
        read_bin(p[0], b, exp_bins[p][b], $sformatf("%s_p%0d_b%0d", tag, p, b));
      end
    end
  endtask

  task automatic check_status(input string tag, input logic busy_e, input logic done_e,
                              input int total_e, input int longest_e);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(busy_e));
    chk({tag, "_done"}, 32'(bus.done), 32'(done_e));
    chk({tag, "_total"}, 32'(bus.total_runs), 32'(total_e));
    chk({tag, "_longest"}, 32'(bus.longest_run), 32'(longest_e));
  endtask

  initial begin
    reset      = 1'b0;
    bus.val    = 1'b0;
    bus.loop   = 1'b0;
    bus.rearm  = 1'b0;
    bus.rd_pol = 1'b0;
    bus.rd_bin = '0;
    step();
    step();
    check_status("reset", 1'b0, 1'b0, 0, 0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b1;
    step();

    // Bits before the first loop are ignored.
    for (int i = 0; i < 6; i++) drive(i[0], 1'b0);
    check_status("idle_toggle", 1'b0, 1'b0, 0, 0);

    // Period 1,1,0,1,1,1,0,0: ones runs 2,3 and zeros runs 1,2.
    drive(1'b1, 1'b1);
    chk("t1_busy_after_loop", 32'(bus.busy), 32'd1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    chk("t1_first_close_total", 32'(bus.total_runs), 32'd1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    check_status("t1_done", 1'b0, 1'b1, 4, 3);
    clear_exp();
    exp_bins[1][1] = 1;
    exp_bins[1][2] = 1;
    exp_bins[0][0] = 1;
    exp_bins[0][1] = 1;
    check_all_bins("t1");

    read_bin(1'b0, 5, 0, "t1_lat_pre");
    bus.rd_pol = 1'b1;
    bus.rd_bin = IW'(1);
    #2;
    chk("t1_lat_hold", 32'(bus.rd_data), 32'd0);
    step();
    chk("t1_lat_new", 32'(bus.rd_data), 32'd1);

    read_bin(1'b1, int'(NB), 0, "t1_oob_24");
    read_bin(1'b0, 31, 0, "t1_oob_31");

    // DONE holds its results through further val/loop activity.
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    check_status("t1_frozen", 1'b0, 1'b1, 4, 3);

    // rearm with loop: back to IDLE only, loop not consumed.
    bus.rearm = 1'b1;
    drive(1'b1, 1'b1);
    bus.rearm = 1'b0;
    check_status("t4_rearm_loop", 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    check_status("t4_still_idle", 1'b0, 1'b0, 0, 0);
    clear_exp();
    check_all_bins("t4_cleared");

    // Thirty ones (first on the loop) then a single zero; rearm mid-run is ignored.
    drive(1'b1, 1'b1);
    for (int i = 0; i < 29; i++) begin
      bus.rearm = (i == 10);
      drive(1'b1, 1'b0);
      bus.rearm = 1'b0;
      if (i == 10) chk("t2_rearm_ignored_busy", 32'(bus.busy), 32'd1);
    end
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b1);
    check_status("t2_done", 1'b0, 1'b1, 2, 30);
    clear_exp();
    exp_bins[1][23] = 1;
    exp_bins[0][0]  = 1;
    check_all_bins("t2");
    read_bin(1'b1, int'(NB), 0, "t2_oob_24");

    // Seventy zeros saturate run_len at 63 and still land in the last bin.
    bus.rearm = 1'b1;
    step();
    bus.rearm = 1'b0;
    check_status("sat_rearm", 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 69; i++) drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    check_status("sat_done", 1'b0, 1'b1, 2, 63);
    read_bin(1'b0, 23, 1, "sat_zeros_b23");
    read_bin(1'b1, 0, 1, "sat_ones_b0");
    read_bin(1'b0, 22, 0, "sat_zeros_b22");

    // Reset in the middle of a collection clears everything.
    bus.rearm = 1'b1;
    step();
    bus.rearm = 1'b0;
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    check_status("mid_active", 1'b1, 1'b0, 2, 2);
    read_bin(1'b1, 1, 1, "mid_ones_b1");
    reset = 1'b0;
    step();
    check_status("mid_reset", 1'b0, 1'b0, 0, 0);
    chk("mid_reset_rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b1;
    read_bin(1'b1, 1, 0, "post_reset_ones_b1");
    read_bin(1'b0, 0, 0, "post_reset_zeros_b0");
    for (int i = 0; i < 4; i++) drive(i[0], 1'b0);
    check_status("post_reset_idle", 1'b0, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
